// File: rtl/wb_slave_router.sv
// Wishbone slave router: decodes the bridge aperture onto four slaves, gates CYC,
// returns read data and ends stalled/unmapped accesses. Macro WB_ROUTER_ERR_CAPTURE_EN adds error capture.
module wb_slave_router #(
  parameter int                    APERWIDTH            = 17,
  parameter int                    APERSIZE             = 9,
  parameter logic [APERWIDTH-1:0]  SLV0_BASE            = 17'h00000,
  parameter logic [APERWIDTH-1:0]  SLV1_BASE            = 17'h00800,
  parameter logic [APERWIDTH-1:0]  SLV2_BASE            = 17'h01000,
  parameter logic [APERWIDTH-1:0]  SLV3_BASE            = 17'h01800,
  parameter logic [31:0]           DEFAULT_READ_VALUE   = 32'hBAD_FAB_AC,
  parameter int                    DEFAULT_CNTR_WIDTH   = 3,
  parameter int                    DEFAULT_CNTR_TIMEOUT = 7
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST,
  input  logic [APERWIDTH-1:0] WBs_ADR,
  input  logic                 WBs_CYC,
  input  logic                 WBs_STB,
  input  logic                 WBs_WE,
  input  logic [3:0]           WBs_BYTE_STB,
  input  logic [31:0]          WBs_WR_DAT,
  output logic [31:0]          WBs_RD_DAT,
  output logic                 WBs_ACK,
  output logic [3:0]           slv_cyc_o,
  input  logic [3:0]           slv_ack_i,
  input  logic [127:0]         slv_rd_dat_i,
  output logic                 err_irq_o,
  output logic [APERWIDTH-1:0] err_addr_o,
  input  logic                 err_clr_i
);

  localparam int DEC_HI = APERWIDTH - 1;
  localparam int DEC_LO = APERSIZE + 2;
  localparam int CW     = DEFAULT_CNTR_WIDTH;
  localparam logic [CW-1:0] CNT_TIMEOUT = CW'(DEFAULT_CNTR_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    TURN = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     sel_q, sel_d;
  logic [3:0]     slv_cyc_q, slv_cyc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ack_q, ack_d;
  logic [31:0]    rd_dat_q, rd_dat_d;
  logic           err_set;
  logic [3:0]     dec_hit;
  logic [31:0]    sel_dat;
  logic           sel_ack;

  // First matching window wins, lowest slave index first.
  function automatic logic [3:0] decode(input logic [APERWIDTH-1:0] adr);
    logic [3:0] hit;
    hit = 4'b0000;
    if (adr[DEC_HI:DEC_LO] == SLV0_BASE[DEC_HI:DEC_LO]) begin
      hit = 4'b0001;
    end else if (adr[DEC_HI:DEC_LO] == SLV1_BASE[DEC_HI:DEC_LO]) begin
      hit = 4'b0010;
    end else if (adr[DEC_HI:DEC_LO] == SLV2_BASE[DEC_HI:DEC_LO]) begin
      hit = 4'b0100;
    end else if (adr[DEC_HI:DEC_LO] == SLV3_BASE[DEC_HI:DEC_LO]) begin
      hit = 4'b1000;
    end else begin
      hit = 4'b0000;
    end
    return hit;
  endfunction

  // Address decode and selected-slave return path.
  always_comb begin
    dec_hit = decode(WBs_ADR);
    sel_ack = |(slv_ack_i & sel_q);
    sel_dat = 32'h0000_0000;
    case (sel_q)
      4'b0001: sel_dat = slv_rd_dat_i[31:0];
      4'b0010: sel_dat = slv_rd_dat_i[63:32];
      4'b0100: sel_dat = slv_rd_dat_i[95:64];
      4'b1000: sel_dat = slv_rd_dat_i[127:96];
      default: sel_dat = 32'h0000_0000;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    slv_cyc_d = slv_cyc_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    rd_dat_d  = rd_dat_q;
    err_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (WBs_CYC && WBs_STB) begin
          if (|dec_hit) begin
            sel_d     = dec_hit;
            slv_cyc_d = dec_hit;
            cnt_d     = CNT_ZERO;
            state_d   = WAIT;
          end else begin
            state_d  = ACK;
            ack_d    = 1'b1;
            rd_dat_d = DEFAULT_READ_VALUE;
            err_set  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!WBs_CYC) begin
          state_d   = IDLE;
          slv_cyc_d = 4'b0000;
          sel_d     = 4'b0000;
        end else if (sel_ack) begin
          // Slave ACK outranks a timeout landing in the same cycle.
          state_d   = ACK;
          ack_d     = 1'b1;
          rd_dat_d  = sel_dat;
          slv_cyc_d = 4'b0000;
        end else if (cnt_q == CNT_TIMEOUT) begin
          state_d   = ACK;
          ack_d     = 1'b1;
          rd_dat_d  = DEFAULT_READ_VALUE;
          slv_cyc_d = 4'b0000;
          err_set   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ACK: begin
        state_d = TURN;
        sel_d   = 4'b0000;
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        sel_d     = 4'b0000;
        slv_cyc_d = 4'b0000;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q   <= IDLE;
      sel_q     <= 4'b0000;
      slv_cyc_q <= 4'b0000;
      cnt_q     <= CNT_ZERO;
      ack_q     <= 1'b0;
      rd_dat_q  <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      slv_cyc_q <= slv_cyc_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      rd_dat_q  <= rd_dat_d;
    end
  end

  assign WBs_ACK    = ack_q;
  assign WBs_RD_DAT = rd_dat_q;
  assign slv_cyc_o  = slv_cyc_q;

`ifdef WB_ROUTER_ERR_CAPTURE_EN
  logic                 err_irq_q, err_irq_d;
  logic [APERWIDTH-1:0] err_addr_q, err_addr_d;

  // Error capture: a new error outranks a clear in the same cycle.
  always_comb begin
    err_irq_d  = err_irq_q;
    err_addr_d = err_addr_q;
    if (err_set) begin
      err_irq_d  = 1'b1;
      err_addr_d = WBs_ADR;
    end else if (err_clr_i) begin
      err_irq_d  = 1'b0;
    end else begin
      err_irq_d  = err_irq_q;
    end
  end

  // Error capture registers.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      err_irq_q  <= 1'b0;
      err_addr_q <= {APERWIDTH{1'b0}};
    end else begin
      err_irq_q  <= err_irq_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_irq_o  = err_irq_q;
  assign err_addr_o = err_addr_q;

  logic err_path_unused;
  assign err_path_unused = &{1'b0, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT, WBs_ADR[DEC_LO-1:0]};
`else
  assign err_irq_o  = 1'b0;
  assign err_addr_o = {APERWIDTH{1'b0}};

  logic err_path_unused;
  assign err_path_unused = &{1'b0, err_set, err_clr_i, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT,
                             WBs_ADR[DEC_LO-1:0]};
`endif

endmodule

// File: tb/tb_wb_slave_router.sv
// Directed bench for wb_slave_router: reactive slave model plus a read-data scoreboard.
module tb_wb_slave_router;

`ifdef WB_ROUTER_ERR_CAPTURE_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [31:0] DEF_RD = 32'hBAD_FAB_AC;

  logic         WB_CLK = 1'b0;
  logic         WB_RST;
  logic [16:0]  WBs_ADR;
  logic         WBs_CYC, WBs_STB, WBs_WE;
  logic [3:0]   WBs_BYTE_STB;
  logic [31:0]  WBs_WR_DAT, WBs_RD_DAT;
  logic         WBs_ACK;
  logic [3:0]   slv_cyc_o, slv_ack_i;
  logic [127:0] slv_rd_dat_i;
  logic         err_irq_o, err_clr_i;
  logic [16:0]  err_addr_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic        exp_irq;
  logic [16:0] exp_addr;

  wb_slave_router dut (
    .WB_CLK(WB_CLK), .WB_RST(WB_RST), .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC),
    .WBs_STB(WBs_STB), .WBs_WE(WBs_WE), .WBs_BYTE_STB(WBs_BYTE_STB),
    .WBs_WR_DAT(WBs_WR_DAT), .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
    .slv_cyc_o(slv_cyc_o), .slv_ack_i(slv_ack_i), .slv_rd_dat_i(slv_rd_dat_i),
    .err_irq_o(err_irq_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
  );

  always #5 WB_CLK = ~WB_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge WB_CLK);
    #1;
  endtask

  // One master access; the slave ACKs on its ack_after-th CYC cycle (0 = never).
  task automatic xfer(input logic [16:0] adr, input logic we, input int slv, input int ack_after,
                      input logic [31:0] dat, input logic [3:0] noise, input int exp_lat,
                      input int gap, input logic [3:0] exp_cyc, input logic [31:0] exp_rd,
                      input logic exp_err);
    int  cyc_cnt;
    bit  seen;
    logic [31:0] exp_pop;
    cyc_cnt = 0;
    seen    = 1'b0;
    exp_q.push_back(exp_rd);
    if (exp_err && ERR_EN) begin
      exp_irq  = 1'b1;
      exp_addr = adr;
    end
    slv_rd_dat_i = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    if (slv >= 0) slv_rd_dat_i[slv*32 +: 32] = dat;
    WBs_ADR = adr; WBs_WE = we; WBs_WR_DAT = ~dat; WBs_BYTE_STB = 4'hF;
    WBs_CYC = 1'b1; WBs_STB = 1'b1;
    step();
    for (int n = 1; n <= 30 && !seen; n++) begin
      if (n == 1 + gap) chk("cyc_select", {28'd0, slv_cyc_o}, {28'd0, exp_cyc});
      if (WBs_ACK === 1'b1) begin
        seen = 1'b1;
        WBs_CYC = 1'b0; WBs_STB = 1'b0; slv_ack_i = 4'b0000;
        chk("ack_latency", n, exp_lat + gap);
        chk("cyc_drop", {28'd0, slv_cyc_o}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          exp_pop = exp_q.pop_front();
          chk("rd_dat", WBs_RD_DAT, exp_pop);
        end
        chk("err_irq", {31'd0, err_irq_o}, {31'd0, exp_irq});
        chk("err_addr", {15'd0, err_addr_o}, {15'd0, exp_addr});
      end else begin
        if (slv >= 0 && slv_cyc_o[slv[1:0]]) cyc_cnt++;
        slv_ack_i = noise |
                    ((slv >= 0 && ack_after != 0 && cyc_cnt == ack_after) ? (4'b0001 << slv[1:0]) : 4'b0000);
        step();
      end
    end
    if (!seen) begin
      chk("ack_missing", 32'd0, 32'd1);
      WBs_CYC = 1'b0; WBs_STB = 1'b0; slv_ack_i = 4'b0000;
      exp_q.delete();
    end
    step();
    chk("ack_pulse", {31'd0, WBs_ACK}, 32'd0);
    chk("rd_hold", WBs_RD_DAT, exp_rd);
  endtask

  task automatic clear_err();
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    exp_irq   = 1'b0;
    chk("irq_clear", {31'd0, err_irq_o}, 32'd0);
  endtask

  initial begin
    WB_RST = 1'b1; WBs_ADR = 17'h0; WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_WE = 1'b0;
    WBs_BYTE_STB = 4'h0; WBs_WR_DAT = 32'h0; slv_ack_i = 4'b0000; slv_rd_dat_i = 128'h0;
    err_clr_i = 1'b0; exp_irq = 1'b0; exp_addr = 17'h0;
    step(); step();
    WB_RST = 1'b0;
    chk("rst_ack", {31'd0, WBs_ACK}, 32'd0);
    chk("rst_rd", WBs_RD_DAT, 32'd0);
    chk("rst_cyc", {28'd0, slv_cyc_o}, 32'd0);
    chk("rst_irq", {31'd0, err_irq_o}, 32'd0);
    step();

    // Slave 1 read, ACK on 3rd CYC cycle.
    xfer(17'h00804, 1'b0, 1, 3, 32'h1234_5678, 4'b0000, 4, 0, 4'b0010, 32'h1234_5678, 1'b0);
    step();
    // Slave 3 write, immediate ACK.
    xfer(17'h01800, 1'b1, 3, 1, 32'h0BAD_CAFE, 4'b0000, 2, 0, 4'b1000, 32'h0BAD_CAFE, 1'b0);
    step();
    // Slave 0 never ACKs: timeout.
    xfer(17'h00000, 1'b0, 0, 0, 32'h5555_AAAA, 4'b0000, 9, 0, 4'b0001, DEF_RD, 1'b1);
    clear_err();
    step();
    // Unmapped access.
    xfer(17'h1F000, 1'b0, -1, 0, 32'h0, 4'b0000, 1, 0, 4'b0000, DEF_RD, 1'b1);
    clear_err();
    step();
    // Slave 2 ACK in the timeout cycle; slave 0 ACK noise throughout.
    xfer(17'h01004, 1'b0, 2, 8, 32'hCAFE_F00D, 4'b0001, 9, 0, 4'b0100, 32'hCAFE_F00D, 1'b0);
    step();

    // Reset while waiting on slave 0.
    slv_rd_dat_i = 128'h0;
    WBs_ADR = 17'h00010; WBs_WE = 1'b0; WBs_CYC = 1'b1; WBs_STB = 1'b1;
    step(); step(); step();
    chk("wait_cyc", {28'd0, slv_cyc_o}, 32'd1);
    WB_RST = 1'b1; WBs_CYC = 1'b0; WBs_STB = 1'b0; slv_ack_i = 4'b0001;
    step();
    WB_RST = 1'b0; slv_ack_i = 4'b0000;
    exp_irq = 1'b0; exp_addr = 17'h0;
    chk("mrst_cyc", {28'd0, slv_cyc_o}, 32'd0);
    chk("mrst_ack", {31'd0, WBs_ACK}, 32'd0);
    chk("mrst_rd", WBs_RD_DAT, 32'd0);
    chk("mrst_addr", {15'd0, err_addr_o}, 32'd0);
    step();
    chk("mrst_ack_dropped", {31'd0, WBs_ACK}, 32'd0);

    // Back-to-back after reset: second request lands in TURN and waits one cycle.
    xfer(17'h00900, 1'b0, 1, 2, 32'h1111_2222, 4'b0000, 3, 0, 4'b0010, 32'h1111_2222, 1'b0);
    xfer(17'h01900, 1'b0, 3, 1, 32'h3333_4444, 4'b0000, 2, 1, 4'b1000, 32'h3333_4444, 1'b0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
